// File: rtl/acc_sequencer.sv
// acc_sequencer: multi-cycle control sequencer for the accumulator processor.
// Walks each instruction through FETCH, LATCH, DECODE, optional IND/OPER
// memory reads, then EXEC or STORE, driving every datapath strobe.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   opcode, addr_mode     stage register fields (sampled in DECODE)
//   acc_zero              accumulator == 0 (conditional jump)
//   mem_ready             data RAM completes the current access
//   iram_en/iram_rd/pc_inc/pc_load/stage_ld   fetch-side strobes
//   dram_en/dram_rd/dram_wr/dram_addr_sel/ind_ld  data-side strobes
//   acc_ld/acc_in_sel/alu_in_sel/alu_op/shift_en/shift_dir  execute controls
//   halted, err           sticky status
//   state                 debug state encoding
module acc_sequencer #(
  parameter int unsigned OPC_W      = 5,
  parameter int unsigned AM_W       = 3,
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WAIT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] opcode,
  input  logic [AM_W-1:0]  addr_mode,
  input  logic             acc_zero,
  input  logic             mem_ready,
  output logic             iram_en,
  output logic             iram_rd,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             stage_ld,
  output logic             dram_en,
  output logic             dram_rd,
  output logic             dram_wr,
  output logic             dram_addr_sel,
  output logic             ind_ld,
  output logic             acc_ld,
  output logic             acc_in_sel,
  output logic             alu_in_sel,
  output logic [1:0]       alu_op,
  output logic             shift_en,
  output logic             shift_dir,
  output logic             halted,
  output logic             err,
  output logic [3:0]       state
);

  localparam int unsigned CNT_W = WAIT_W + 1;

  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_SHL = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SHR = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_HLT = '1;

  localparam logic [1:0] AM_IMM = 2'd0;
  localparam logic [1:0] AM_IND = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_LATCH  = 4'd1,
    S_DECODE = 4'd2,
    S_IND    = 4'd3,
    S_OPER   = 4'd4,
    S_EXEC   = 4'd5,
    S_STORE  = 4'd6,
    S_HALT   = 4'd7
  } state_e;

  state_e             state_q, state_d;
  logic [OPC_W-1:0]   op_q, op_d;
  logic [1:0]         mode_q, mode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               err_q, err_d;

  logic [CNT_W-1:0]   wait_inc_c;
  logic               wait_expire_c;

  // Only addr_mode[1:0] is decoded; upper bits are reserved.
  if (AM_W > 2) begin : g_mode_hi
    logic unused_mode_hi;
    assign unused_mode_hi = ^addr_mode[AM_W-1:2];
  end

  // Timeout fires on the not-ready cycle that brings the count to the limit.
  assign wait_inc_c    = {1'b0, wait_q} + CNT_W'(1);
  assign wait_expire_c = (WAIT_LIMIT != 0) && (wait_inc_c == CNT_W'(WAIT_LIMIT));

  // State and captured-instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      mode_q  <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next-state and strobe decode; everything is held at 0 while in reset.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    mode_d        = mode_q;
    wait_d        = '0;
    err_d         = err_q;
    iram_en       = 1'b0;
    iram_rd       = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    stage_ld      = 1'b0;
    dram_en       = 1'b0;
    dram_rd       = 1'b0;
    dram_wr       = 1'b0;
    dram_addr_sel = 1'b0;
    ind_ld        = 1'b0;
    acc_ld        = 1'b0;
    acc_in_sel    = 1'b0;
    alu_in_sel    = 1'b0;
    alu_op        = 2'd0;
    shift_en      = 1'b0;
    shift_dir     = 1'b0;
    halted        = 1'b0;
    err           = 1'b0;
    state         = 4'd0;

    if (!reset) begin
      state = state_q;
      err   = err_q;

      unique case (state_q)
        S_FETCH: begin
          iram_en = 1'b1;
          iram_rd = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_LATCH;
        end

        S_LATCH: begin
          stage_ld = 1'b1;
          state_d  = S_DECODE;
        end

        // Decode works on the live stage register, then freezes it.
        S_DECODE: begin
          op_d    = opcode;
          mode_d  = addr_mode[1:0];
          state_d = S_FETCH;
          if (opcode == OP_HLT) begin
            state_d = S_HALT;
          end else if (opcode == OP_JMP) begin
            pc_load = 1'b1;
          end else if (opcode == OP_JZ) begin
            pc_load = acc_zero;
          end else if ((opcode == OP_SHL) || (opcode == OP_SHR)) begin
            state_d = S_EXEC;
          end else if ((opcode == OP_LDA) || (opcode == OP_STA) || (opcode == OP_ADD) ||
                       (opcode == OP_SUB) || (opcode == OP_AND)) begin
            if (addr_mode[1:0] == AM_IMM) begin
              if (opcode == OP_STA) begin
                err_d   = 1'b1;
                state_d = S_HALT;
              end else begin
                state_d = S_EXEC;
              end
            end else if (addr_mode[1:0] == AM_IND) begin
              state_d = S_IND;
            end else begin
              state_d = (opcode == OP_STA) ? S_STORE : S_OPER;
            end
          end
        end

        // Pointer read; the indirect register loads on the completing cycle.
        S_IND: begin
          dram_en = 1'b1;
          dram_rd = 1'b1;
          if (mem_ready) begin
            ind_ld  = 1'b1;
            state_d = (op_q == OP_STA) ? S_STORE : S_OPER;
          end else if (wait_expire_c) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            wait_d = WAIT_W'(wait_inc_c);
          end
        end

        S_OPER: begin
          dram_en       = 1'b1;
          dram_rd       = 1'b1;
          dram_addr_sel = (mode_q == AM_IND);
          if (mem_ready) begin
            state_d = S_EXEC;
          end else if (wait_expire_c) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            wait_d = WAIT_W'(wait_inc_c);
          end
        end

        S_STORE: begin
          dram_en       = 1'b1;
          dram_wr       = 1'b1;
          dram_addr_sel = (mode_q == AM_IND);
          if (mem_ready) begin
            state_d = S_FETCH;
          end else if (wait_expire_c) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            wait_d = WAIT_W'(wait_inc_c);
          end
        end

        S_EXEC: begin
          acc_ld  = 1'b1;
          state_d = S_FETCH;
          if (op_q == OP_LDA) begin
            acc_in_sel = 1'b1;
            alu_op     = 2'd3;
            alu_in_sel = (mode_q == AM_IMM);
          end else if (op_q == OP_ADD) begin
            alu_op     = 2'd0;
            alu_in_sel = (mode_q == AM_IMM);
          end else if (op_q == OP_SUB) begin
            alu_op     = 2'd1;
            alu_in_sel = (mode_q == AM_IMM);
          end else if (op_q == OP_AND) begin
            alu_op     = 2'd2;
            alu_in_sel = (mode_q == AM_IMM);
          end else if (op_q == OP_SHL) begin
            shift_en = 1'b1;
          end else if (op_q == OP_SHR) begin
            shift_en  = 1'b1;
            shift_dir = 1'b1;
          end
        end

        S_HALT: begin
          halted = 1'b1;
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/acc_sequencer.md
# acc_sequencer

Parametrised multi-cycle control sequencer for the accumulator processor; the next generation of the fetch/latch controller. It walks every instruction through fetch, stage-register latch, decode, optional indirect-address and operand reads, and execute or store. It drives every datapath strobe, supports a data-RAM ready handshake with a wait-state timeout, and adds conditional jump and halt. It sits between the stage register outputs (opcode, addressing mode) and the PC, RAMs, accumulator, ALU and shifter.

## Interface
- OPC_W, 5: opcode width (≥4); all-ones opcode = HLT.
- AM_W, 3: addressing-mode width (≥2); only bits [1:0] decoded.
- WAIT_LIMIT, 15: max consecutive not-ready cycles in a memory state; 0 disables the timeout.
- WAIT_W, 4: wait counter width; must hold WAIT_LIMIT.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- opcode  in  OPC_W  stage register opcode field.
- addr_mode  in  AM_W  stage register mode: 0 immediate, 1 direct, 2 indirect, 3 direct.
- acc_zero  in  1  accumulator equals zero.
- mem_ready  in  1  data RAM completes the current access this cycle.
- iram_en, iram_rd, pc_inc, pc_load  out  1  instruction RAM and PC strobes.
- stage_ld  out  1  stage register load.
- dram_en, dram_rd, dram_wr, dram_addr_sel  out  1  data RAM strobes; addr_sel 1 = indirect register.
- ind_ld  out  1  indirect address register load.
- acc_ld, acc_in_sel  out  1  accumulator load; in_sel 1 = data operand, 0 = ALU/shifter.
- alu_in_sel  out  1  1 = immediate field, 0 = data RAM.
- alu_op  out  2  0 ADD, 1 SUB, 2 AND, 3 PASS.
- shift_en, shift_dir  out  1  shifter select; dir 1 = right.
- halted, err  out  1  sticky status.
- state  out  4  debug encoding of the current state.

## Operation
- Opcodes: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 AND, 5 SHL, 6 SHR, 7 JMP, 8 JZ, 9 NOP, all-ones HLT; any other code = NOP.
- opcode and addr_mode are captured internally in DECODE and used until the next DECODE.
- States: FETCH(0), LATCH(1), DECODE(2), IND(3), OPER(4), EXEC(5), STORE(6), HALT(7).
- FETCH: iram_en=iram_rd=pc_inc=1 → LATCH.
- LATCH: stage_ld=1 → DECODE.
- DECODE:
  - HLT → HALT. NOP → FETCH.
  - JMP, or JZ with acc_zero=1: pc_load=1 → FETCH. JZ with acc_zero=0 → FETCH.
  - SHL/SHR → EXEC, regardless of mode.
  - STA immediate: illegal; err=1 → HALT.
  - Immediate LDA/ADD/SUB/AND → EXEC.
  - Direct mode → OPER (STORE for STA).
  - Indirect mode → IND.
- IND: dram_en=dram_rd=1, addr_sel=0. On mem_ready: ind_ld=1 → OPER (STORE for STA).
- OPER: dram_en=dram_rd=1, addr_sel=(mode==2). On mem_ready → EXEC.
- STORE: dram_en=dram_wr=1, addr_sel=(mode==2). On mem_ready → FETCH.
- EXEC: acc_ld=1 → FETCH.
  - LDA: acc_in_sel=1, alu_op=3.
  - ADD/SUB/AND: alu_op 0/1/2, acc_in_sel=0.
  - alu_in_sel=1 only for immediate mode.
  - SHL/SHR: shift_en=1, shift_dir=0/1.
- HALT: halted=1, all strobes 0. Held until reset.
- Wait counter:
  - Cleared on entry to IND/OPER/STORE; increments each cycle mem_ready=0.
  - When it reaches WAIT_LIMIT with mem_ready still 0: err=1 → HALT.
  - mem_ready=1 in the same cycle wins.
- Any output not listed for a state is 0.

## Timing
- All outputs are Moore decodes of the state plus the captured opcode/mode, except pc_load, which also depends on acc_zero in DECODE.
- While reset=1, every output is forced to 0. On the edge with reset=1: state←FETCH, counter←0, err←0, halted←0.
- The first FETCH strobe appears in the first cycle after reset deasserts.
- Reset mid-instruction aborts it with no further strobes.
- Instruction cycles with mem_ready tied to 1:
  - NOP/JMP/JZ: 3.
  - Immediate op, shift, or direct STA: 4.
  - Direct op or indirect STA: 5.
  - Indirect op: 6.
- Each not-ready cycle adds 1 cycle.

## Test plan
- Reset held 3 cycles, then released → all outputs 0 during reset; next cycle state=0 with iram_en=iram_rd=pc_inc=1; the cycle after, stage_ld=1.
- ADD immediate (opcode 2, mode 0) → state sequence 0,1,2,5; in EXEC: acc_ld=1, alu_in_sel=1, alu_op=0.
- LDA indirect with mem_ready low 2 cycles in IND → IND lasts 3 cycles with ind_ld=1 in the last; OPER has addr_sel=1; EXEC has acc_in_sel=1, alu_op=3; 8 cycles total.
- JZ: with acc_zero=1 → pc_load=1 in DECODE; with acc_zero=0 → pc_load stays 0; both return to FETCH after 3 cycles.
- Direct STA with mem_ready stuck 0, WAIT_LIMIT=15 → err=1 and halted=1 after the 15th not-ready cycle in STORE; state stays 7 until reset.
- HLT (opcode 31) → halted=1; no strobes for 20 cycles; reset recovers to FETCH with err=0.
